reflet_float_mant_mult_seq: RTL
===============================

Name: reflet_float_mant_mult_seq

Overview:
- Sequential shift-add unsigned multiplier for the mantissa datapath of the floating-point multiplier.
- It is the stage directly upstream of the float multiplier's normalise/exponent logic. It takes the two hidden-bit-extended mantissas and produces the full double-width product that the multiplier consumes.
- It uses the same enable/ready contract as the multiplier: enable held high requests a product, and ready flags it valid.
- It trades latency (one bit per cycle) for area, so it suits small FPGA targets.

Parameters:
- size, 24, operand width in bits (mantissa_size+1; 24 for 32-bit floats, 11 for 16-bit floats).

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  asynchronous, active-low reset
- enable  input  1  request; held high for the whole operation, low aborts/clears
- in1  input  size  multiplicand (unsigned)
- in2  input  size  multiplier (unsigned)
- mult  output  2*size  registered product in1*in2, valid while ready=1
- ready  output  1  high when mult holds the product of the latched operands

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, ready=0, mult=0, counter=0, internal accumulator=0. This takes effect immediately regardless of clk, including mid-operation.
- States: IDLE, RUN, DONE.
- IDLE:
  - ready=0.
  - On an edge with enable=1: latch in1 into the multiplicand register and load the accumulator as {(size+1)'b0, in2}. Set counter=0 and state=RUN.
  - mult is cleared to 0 on this edge.
- RUN, one step per edge while enable=1:
  - If acc[0]=1, the upper size+1 bits of acc are increased by the multiplicand, with the carry kept in the extra bit.
  - The whole accumulator then shifts right by 1.
  - counter increments.
  - When the step with counter=size-1 completes: mult<=acc result (lower 2*size bits after the shift), state=DONE, ready<=1.
- Latency: ready rises on the (size+1)th rising edge after the first edge that samples enable=1 in IDLE. For size=24 this is 25 edges.
- DONE:
  - ready=1 and mult is held stable while enable stays 1.
  - Input changes are ignored; operands are not re-sampled.
- enable=0 in RUN or DONE: next edge goes to IDLE, clears ready to 0 and clears mult to 0. A partial product is never presented.
- A new operation requires enable to be low for at least one edge (IDLE re-entry). Back-to-back throughput is one product per size+2 cycles.
- Operands are sampled only at the IDLE->RUN edge. Changing in1/in2 during RUN has no effect on the result.
- Zero operands take no shortcut. Latency is always size+1; the result is 0.
- Arithmetic:
  - Accumulator width is 2*size+1 bits. The top bit absorbs the add carry before the shift, so no overflow is possible.
  - The final product fits exactly in 2*size bits. The MSB (bit 2*size-1) is 1 iff the product is >= 2^(2*size-1), which the downstream stage uses for normalisation.
- ready and mult are purely registered, with no combinational path from inputs.

Test Plan:
- Reset and idle: hold reset=0, then release with enable=0 for 5 cycles -> ready=0 and mult=0 throughout.
- Unity product: size=24, in1=in2=24'h800000, enable held high -> ready rises exactly on edge 25 with mult=48'h400000000000. mult stays stable for 10 further cycles with enable high.
- Maximum operands: in1=in2=24'hFFFFFF -> mult=48'hFFFFFE000001 at edge 25. Then in1=24'hC00000, in2=24'h800000 (1.5*1.0) after one enable-low cycle -> mult=48'h600000000000, MSB=0.
- Operand change mid-run: start with in1=24'hA00000, in2=24'hC00000, then change both to 0 at cycle 5 -> result still 48'h780000000000 at edge 25.
- Abort and restart: drop enable at cycle 10 of RUN -> ready stays 0 and mult=0 next edge. Re-assert enable with in1=in2=24'h800001 -> mult=48'h400001000001 at edge 25 after restart.
- Async reset mid-run and small size: with size=4, in1=4'hF, in2=4'hD, assert reset at cycle 3 between clock edges -> ready and mult go to 0 immediately. After release and restart -> mult=8'hC3 with ready at edge 5.

Source files
------------

// File: rtl/reflet_float_mant_mult_seq.sv
// Sequential shift-add mantissa multiplier for the float multiplier.
// Retires one multiplier bit per clock; result presented with ready.
module reflet_float_mant_mult_seq #(
    parameter int size = 24
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [size-1:0]   in1,
    input  logic [size-1:0]   in2,
    output logic [2*size-1:0] mult,
    output logic              ready
);

    localparam int CW = $clog2(size) + 1;
    localparam logic [CW-1:0] LAST = CW'(size - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [size-1:0]   mcand_q, mcand_d;
    logic [2*size:0]   acc_q, acc_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2*size-1:0] mult_q, mult_d;
    logic              ready_q, ready_d;

    logic [size:0]     hi_sum;
    logic [2*size:0]   acc_step;

    // Upper half carries into its extra bit before the shift drops it down
    always_comb begin
        hi_sum   = acc_q[2*size:size]
                 + (acc_q[0] ? {1'b0, mcand_q} : {(size+1){1'b0}});
        acc_step = {hi_sum, acc_q[size-1:0]} >> 1;
    end

    always_comb begin
        state_d = state_q;
        mcand_d = mcand_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        mult_d  = mult_q;
        ready_d = ready_q;
        unique case (state_q)
            IDLE: begin
                ready_d = 1'b0;
                mult_d  = '0;
                if (enable) begin
                    mcand_d = in1;
                    acc_d   = {{(size+1){1'b0}}, in2};
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!enable) begin
                    state_d = IDLE;
                    ready_d = 1'b0;
                    mult_d  = '0;
                end else begin
                    acc_d = acc_step;
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == LAST) begin
                        mult_d  = acc_step[2*size-1:0];
                        ready_d = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (!enable) begin
                    state_d = IDLE;
                    ready_d = 1'b0;
                    mult_d  = '0;
                end
            end
            default: begin
                state_d = IDLE;
                ready_d = 1'b0;
                mult_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            mcand_q <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            mult_q  <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            mcand_q <= mcand_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            mult_q  <= mult_d;
            ready_q <= ready_d;
        end
    end

    assign mult  = mult_q;
    assign ready = ready_q;

endmodule
